// File: rtl/bvb_bank_scheduler.sv
// Bank sequencer for the banked vector RAM: walks banks, drives RAM address, grants id->vector moves.
// Optional build macro BVB_BANK_SKIP_EN jumps straight to the next requested bank instead of stepping.
module bvb_bank_scheduler #(
    parameter int CHANNEL_NUM    = 4,
    parameter int COL_ID_SIZE    = 10,
    parameter int RAM_SPLIT_BITS = 3,
    parameter int RAM_SPLITS     = 8,
    parameter int BVB_ADDR_SIZE  = 12
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CHANNEL_NUM*COL_ID_SIZE-1:0] id,
    input  logic [CHANNEL_NUM-1:0]             id_fifo_empty,
    input  logic [CHANNEL_NUM-1:0]             vec_fifo_full,
    input  logic [BVB_ADDR_SIZE-1:0]           image_base,
    input  logic                               image_load,
    input  logic                               image_done,
    output logic [CHANNEL_NUM-1:0]             id_fifo_read,
    output logic [CHANNEL_NUM-1:0]             vec_fifo_wr_en,
    output logic [BVB_ADDR_SIZE-1:0]           ram_addr,
    output logic [RAM_SPLIT_BITS-1:0]          bank,
    output logic                               busy,
    output logic                               image_complete
);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    localparam logic [RAM_SPLIT_BITS-1:0] LAST_BANK = RAM_SPLIT_BITS'(RAM_SPLITS - 1);
    localparam logic [RAM_SPLIT_BITS-1:0] BANK_ONE  = RAM_SPLIT_BITS'(1);
    localparam int                        PAD_W     = BVB_ADDR_SIZE - RAM_SPLIT_BITS;

    state_t                              state, state_n;
    logic [RAM_SPLIT_BITS-1:0]           bank_n, next_bank;
    logic [BVB_ADDR_SIZE-1:0]            image_start, start_n;
    logic [CHANNEL_NUM*RAM_SPLIT_BITS-1:0] bank_ids;
    logic [CHANNEL_NUM-1:0]              pend, grant;
    logic                                id_unused;

    function automatic logic [RAM_SPLIT_BITS-1:0] seq_next(input logic [RAM_SPLIT_BITS-1:0] b);
        return (b == LAST_BANK) ? '0 : b + BANK_ONE;
    endfunction

`ifdef BVB_BANK_SKIP_EN
    // First bank after b (with wrap) that some non-empty head targets; plain step if none.
    function automatic logic [RAM_SPLIT_BITS-1:0] skip_next(
        input logic [RAM_SPLIT_BITS-1:0]             b,
        input logic [CHANNEL_NUM*RAM_SPLIT_BITS-1:0] ids,
        input logic [CHANNEL_NUM-1:0]                valid
    );
        logic [RAM_SPLIT_BITS-1:0] cand, res;
        logic                      found;
        cand  = b;
        res   = seq_next(b);
        found = 1'b0;
        for (int off = 1; off < RAM_SPLITS; off++) begin
            cand = seq_next(cand);
            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                if (!found && valid[ch] && ids[ch*RAM_SPLIT_BITS +: RAM_SPLIT_BITS] == cand) begin
                    res   = cand;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    assign next_bank = skip_next(bank, bank_ids, ~id_fifo_empty);
`else
    assign next_bank = seq_next(bank);
`endif

    // Only the bank-select bits of each id matter here; the column bits pass through untouched.
    assign id_unused = ^id;

    always_comb begin
        bank_ids = '0;
        pend     = '0;
        for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
            bank_ids[ch*RAM_SPLIT_BITS +: RAM_SPLIT_BITS] = id[(ch+1)*COL_ID_SIZE-1 -: RAM_SPLIT_BITS];
            pend[ch] = ~id_fifo_empty[ch] &
                       (bank_ids[ch*RAM_SPLIT_BITS +: RAM_SPLIT_BITS] == bank);
        end
    end

    always_comb begin
        state_n        = state;
        bank_n         = bank;
        start_n        = image_start;
        grant          = '0;
        image_complete = 1'b0;
        case (state)
            IDLE: begin
                if (image_load) begin
                    start_n = image_base;
                    bank_n  = '0;
                    state_n = SETTLE;
                end
            end
            SETTLE: state_n = RUN;
            RUN: begin
                grant = pend & ~vec_fifo_full;
                if (|pend) begin
                    state_n = RUN;
                end else if (~&id_fifo_empty) begin
                    bank_n  = next_bank;
                    state_n = SETTLE;
                end else if (image_done) begin
                    image_complete = 1'b1;
                    state_n        = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ram_addr always tracks image_start + bank, so it is simply reloaded every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bank        <= '0;
            image_start <= '0;
            ram_addr    <= '0;
        end else begin
            state       <= state_n;
            bank        <= bank_n;
            image_start <= start_n;
            ram_addr    <= start_n + {{PAD_W{1'b0}}, bank_n};
        end
    end

    assign id_fifo_read   = grant;
    assign vec_fifo_wr_en = grant;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_bvb_bank_scheduler.sv
// Randomized bench for bvb_bank_scheduler against a queue-based cycle model of the id FIFOs.
module tb_bvb_bank_scheduler;
    localparam int CH = 4;
    localparam int CW = 10;
    localparam int SB = 3;
    localparam int NS = 8;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic [CH*CW-1:0] id;
    logic [CH-1:0] id_fifo_empty, vec_fifo_full, id_fifo_read, vec_fifo_wr_en;
    logic [AW-1:0] image_base, ram_addr;
    logic image_load, image_done, busy, image_complete;
    logic [SB-1:0] bank;

    bvb_bank_scheduler dut (
        .clk(clk), .rst_n(rst_n), .id(id), .id_fifo_empty(id_fifo_empty),
        .vec_fifo_full(vec_fifo_full), .image_base(image_base), .image_load(image_load),
        .image_done(image_done), .id_fifo_read(id_fifo_read), .vec_fifo_wr_en(vec_fifo_wr_en),
        .ram_addr(ram_addr), .bank(bank), .busy(busy), .image_complete(image_complete)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] q [CH][$];
    logic [CH-1:0] full_r = '0;
    logic          done_r = 1'b0;
    logic          load_r = 1'b0;
    logic [AW-1:0] base_r = '0;

    // Model: active image, cycles still to wait before grants, current bank, image base.
    bit m_active = 1'b0;
    int m_wait   = 0;
    int m_bank   = 0;
    int m_base   = 0;

    logic [CH-1:0] last_grant;
    logic          last_cmpl;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] mk_id(input int b);
        logic [SB-1:0] bb;
        bb = SB'(b);
        return {bb, (CW-SB)'($urandom)};
    endfunction

    function automatic int head_bank(input int ch);
        logic [CW-1:0] h;
        h = q[ch][0];
        return int'(h[CW-1 -: SB]);
    endfunction

    function automatic int model_next_bank();
        int best, d;
        best = -1;
`ifdef BVB_BANK_SKIP_EN
        for (int ch = 0; ch < CH; ch++) begin
            if (q[ch].size() > 0) begin
                d = (head_bank(ch) - m_bank + NS) % NS;
                if (d != 0 && (best < 0 || d < ((best - m_bank + NS) % NS)))
                    best = head_bank(ch);
            end
        end
`endif
        if (best < 0) best = (m_bank + 1) % NS;
        return best;
    endfunction

    task automatic apply_inputs();
        for (int ch = 0; ch < CH; ch++) begin
            if (q[ch].size() > 0) id[ch*CW +: CW] = q[ch][0];
            else                  id[ch*CW +: CW] = CW'($urandom);
            id_fifo_empty[ch] = (q[ch].size() == 0);
        end
        vec_fifo_full = full_r;
        image_done    = done_r;
        image_load    = load_r;
        image_base    = base_r;
    endtask

    task automatic step();
        logic [CH-1:0] pend, eg;
        bit run, alle, ec;
        apply_inputs();
        @(negedge clk);
        run  = m_active && (m_wait == 0);
        alle = 1'b1;
        pend = '0;
        for (int ch = 0; ch < CH; ch++) begin
            if (q[ch].size() > 0) begin
                alle = 1'b0;
                if (head_bank(ch) == m_bank) pend[ch] = 1'b1;
            end
        end
        eg = run ? (pend & ~full_r) : '0;
        ec = run && (pend == 0) && alle && done_r;
        last_grant = id_fifo_read;
        last_cmpl  = image_complete;
        check_eq("grant", id_fifo_read, eg);
        check_eq("wr_en", vec_fifo_wr_en, eg);
        check_eq("busy", busy, m_active);
        check_eq("bank", bank, m_bank);
        check_eq("ram_addr", ram_addr, (m_base + m_bank) % (1 << AW));
        check_eq("complete", image_complete, ec);
        if (!m_active) begin
            if (load_r) begin
                m_active = 1'b1; m_wait = 1; m_base = base_r; m_bank = 0;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (pend != 0) begin
            m_wait = 0;
        end else if (!alle) begin
            m_bank = model_next_bank();
            m_wait = 1;
        end else if (done_r) begin
            m_active = 1'b0;
        end
        for (int ch = 0; ch < CH; ch++)
            if (eg[ch]) void'(q[ch].pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input logic [AW-1:0] b);
        base_r = b;
        load_r = 1'b1;
        step();
        load_r = 1'b0;
    endtask

    task automatic wait_run_bank(input int b);
        int n;
        n = 0;
        while (!(m_active && m_wait == 0 && m_bank == b) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) check_eq("wait_bank", bank, b);
    endtask

    initial begin
        int n, exp_lat;
        rst_n = 1'b0;
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", id_fifo_read, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_bank", bank, 0);
        check_eq("rst_addr", ram_addr, 0);
        check_eq("rst_cmpl", image_complete, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load at 0x100, ch0 head in bank 0
        q[0].push_back(mk_id(0));
        load_image(12'h100);
        check_eq("t2_addr", ram_addr, 12'h100);
        check_eq("t2_busy", busy, 1);
        step();
        check_eq("t2_settle", last_grant, 4'b0000);
        step();
        check_eq("t2_grant", last_grant, 4'b0001);

        // ch0 and ch2 in bank 3, ch2 vector FIFO full
        q[0].push_back(mk_id(3));
        q[2].push_back(mk_id(3));
        full_r = 4'b0100;
        wait_run_bank(3);
        step();
        check_eq("t3_grant", last_grant, 4'b0001);
        repeat (3) step();
        check_eq("t3_hold", bank, 3);
        full_r = '0;
        step();
        check_eq("t3_ch2", last_grant, 4'b0100);

        // only ch1 non-empty, bank 5 requested from bank 1
        q[0].push_back(mk_id(1));
        wait_run_bank(1);
        step();
        q[1].push_back(mk_id(5));
`ifdef BVB_BANK_SKIP_EN
        exp_lat = 2;
`else
        exp_lat = 8;
`endif
        n = 0;
        step();
        while (!last_grant[1] && n < 40) begin
            n++;
            step();
        end
        check_eq("t4_lat", n, exp_lat);
        check_eq("t4_addr", ram_addr, 12'h105);

        // wrap from bank 7 to bank 0
        q[0].push_back(mk_id(7));
        wait_run_bank(7);
        step();
        q[3].push_back(mk_id(0));
        n = 0;
        step();
        while (!last_grant[3] && n < 40) begin
            n++;
            step();
        end
        check_eq("t5_grant", last_grant, 4'b1000);
        check_eq("t5_bank", bank, 0);

        // load ignored in RUN, then completion
        base_r = 12'hABC;
        load_r = 1'b1;
        step();
        load_r = 1'b0;
        check_eq("t6_addr", ram_addr, 12'h100);
        done_r = 1'b1;
        step();
        check_eq("t6_cmpl", last_cmpl, 1);
        check_eq("t6_busy", busy, 0);
        done_r = 1'b0;

        // asynchronous reset while grants are active
        for (int ch = 0; ch < CH; ch++)
            repeat (4) q[ch].push_back(mk_id(0));
        load_image(AW'($urandom));
        step();
        step();
        apply_inputs();
        #1;
        check_eq("t1_pre", id_fifo_read, 4'b1111);
        rst_n = 1'b0;
        #1;
        check_eq("t1_grant", id_fifo_read, 0);
        check_eq("t1_wr", vec_fifo_wr_en, 0);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_addr", ram_addr, 0);
        check_eq("t1_bank", bank, 0);
        m_active = 1'b0; m_wait = 0; m_bank = 0; m_base = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t1_idle", busy, 0);
        check_eq("t1_addr2", ram_addr, 0);

        // randomized images
        for (int img = 0; img < 6; img++) begin
            load_image(AW'($urandom));
            for (int c = 0; c < 80; c++) begin
                for (int ch = 0; ch < CH; ch++)
                    if ($urandom_range(0, 3) == 0 && q[ch].size() < 8)
                        q[ch].push_back(mk_id($urandom_range(0, NS - 1)));
                full_r = CH'($urandom & $urandom);
                load_r = ($urandom_range(0, 15) == 0);
                done_r = ($urandom_range(0, 31) == 0);
                base_r = AW'($urandom);
                step();
            end
            load_r = 1'b0;
            done_r = 1'b1;
            n = 0;
            while (m_active && n < 300) begin
                full_r = CH'($urandom & $urandom);
                step();
                n++;
            end
            check_eq("drain", busy, 0);
            done_r = 1'b0;
            full_r = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
